lzd_normalizer: RTL and testbench

- Parametrised, handshaked leading-zero / leading-sign normaliser for the mathlib datapath.
- Left-shifts an operand so its most significant significant bit sits at the MSB, and returns the shift count.
- Supports unsigned and two's-complement mode per transaction, per-transaction bypass, and a sideband tag.
- Two-stage valid/ready pipeline with backpressure, used ahead of fixed-to-float conversion and divider prescaling.

---
 rtl/mathlib_pkg.sv | 34 +++
 rtl/lzd_chunk_select.sv | 53 +++++
 rtl/lzd_normalizer.sv | 131 +++++++++++++
 tb/tb_lzd_normalizer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mathlib_pkg.sv
// Shared mathlib helpers: per-chunk leading-zero count and chunk-count arithmetic
// for the leading-zero / leading-sign normaliser.
package mathlib_pkg;

    localparam int CHUNK_MAX = 8;
    localparam int CNTBITS   = 3;

    typedef struct packed {
        logic               nz;
        logic [CNTBITS-1:0] cnt;
    } chunk_lzc_t;

    function automatic int nch_of(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    function automatic int padw_of(input int width, input int chunk);
        return nch_of(width, chunk) * chunk;
    endfunction

    // The chunk lives in v[cw-1:0] with its MSB at v[cw-1]; cnt is only meaningful when nz=1.
    function automatic chunk_lzc_t lzc_chunk(input logic [CHUNK_MAX-1:0] v, input int cw);
        chunk_lzc_t r;
        r = '0;
        for (int i = CHUNK_MAX - 1; i >= 0; i--) begin
            if (i < cw && v[i] && !r.nz) begin
                r.nz  = 1'b1;
                r.cnt = CNTBITS'(cw - 1 - i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lzd_chunk_select.sv
// Second-stage logic: MSB-first priority select over chunk flags and the
// left barrel shift that produces the normalised operand.
module lzd_chunk_select
    import mathlib_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CHUNK     = 8,
    parameter int SHIFTBITS = $clog2(WIDTH + 1)
) (
    input  chunk_lzc_t [nch_of(WIDTH, CHUNK)-1:0] i_lzc,
    input  logic [WIDTH-1:0]                     i_m,
    input  logic                                 i_signed,
    input  logic                                 i_noscale,
    output logic [WIDTH-1:0]                     o_m,
    output logic [SHIFTBITS-1:0]                 o_shift,
    output logic                                 o_zero
);

    localparam int NCH = nch_of(WIDTH, CHUNK);

    logic                 w_found;
    logic                 w_neg1;
    logic [SHIFTBITS-1:0] w_lz;
    logic [SHIFTBITS-1:0] w_shift;

    // Chunk NCH-1 holds the operand MSBs; scanning upward lets the highest nonzero chunk win.
    always_comb begin
        w_found = 1'b0;
        w_lz    = '0;
        for (int k = 0; k < NCH; k++) begin
            if (i_lzc[k].nz) begin
                w_found = 1'b1;
                w_lz    = SHIFTBITS'((NCH - 1 - k) * CHUNK + int'(i_lzc[k].cnt));
            end
        end
    end

    // An empty detect vector in signed mode with the sign set can only be all ones.
    assign w_neg1  = i_signed & i_m[WIDTH-1] & ~w_found;
    assign w_shift = w_found ? w_lz : (w_neg1 ? SHIFTBITS'(WIDTH - 1) : '0);

    always_comb begin
        o_zero = ~w_found & ~w_neg1;
        if (i_noscale) begin
            o_m     = i_m;
            o_shift = '0;
        end else begin
            o_m     = i_m << w_shift;
            o_shift = w_shift;
        end
    end

endmodule

// File: rtl/lzd_normalizer.sv
// Two-stage handshaked leading-zero / leading-sign normaliser: S1 computes
// per-chunk detect results, S2 selects the count and shifts the operand.
module lzd_normalizer
    import mathlib_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CHUNK     = 8,
    parameter int SHIFTBITS = $clog2(WIDTH + 1),
    parameter int TAGBITS   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_m,
    input  logic                 i_signed,
    input  logic                 i_noscale,
    input  logic [TAGBITS-1:0]   i_tag,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH-1:0]     o_m,
    output logic [SHIFTBITS-1:0] o_shift,
    output logic                 o_zero,
    output logic [TAGBITS-1:0]   o_tag
);

    // Handshake: a transfer happens on a cycle where both valid and ready are high at the
    // rising edge; ready never depends on the same-side valid, so no combinational loop forms.

    localparam int NCH = nch_of(WIDTH, CHUNK);
    localparam int PW  = padw_of(WIDTH, CHUNK);

    logic [WIDTH-1:0]       w_det;
    logic [PW-1:0]          w_pad;
    chunk_lzc_t [NCH-1:0]   w_lzc;
    logic                   w_s1_load;
    logic                   w_s2_load;
    logic [WIDTH-1:0]       w_sel_m;
    logic [SHIFTBITS-1:0]   w_sel_shift;
    logic                   w_sel_zero;

    logic                   r_v1;
    logic [WIDTH-1:0]       r_m1;
    logic                   r_signed1;
    logic                   r_noscale1;
    logic [TAGBITS-1:0]     r_tag1;
    chunk_lzc_t [NCH-1:0]   r_lzc1;

    logic                   r_v2;
    logic [WIDTH-1:0]       r_m2;
    logic [SHIFTBITS-1:0]   r_shift2;
    logic                   r_zero2;
    logic [TAGBITS-1:0]     r_tag2;

    // Signed mode looks for the first bit that differs from the sign; the zero appended at
    // the bottom keeps the vector WIDTH wide and can never be mistaken for a real bit.
    always_comb begin
        if (i_signed) begin
            w_det = {i_m[WIDTH-2:0] ^ {(WIDTH-1){i_m[WIDTH-1]}}, 1'b0};
        end else begin
            w_det = i_m;
        end
        w_pad = '0;
        w_pad[PW-1 -: WIDTH] = w_det;
        for (int k = 0; k < NCH; k++) begin
            w_lzc[k] = lzc_chunk(CHUNK_MAX'(w_pad[k*CHUNK +: CHUNK]), CHUNK);
        end
    end

    assign w_s2_load = ~r_v2 | i_ready;
    assign w_s1_load = ~r_v1 | w_s2_load;
    assign o_ready   = w_s1_load;

    lzd_chunk_select #(
        .WIDTH     (WIDTH),
        .CHUNK     (CHUNK),
        .SHIFTBITS (SHIFTBITS)
    ) u_select (
        .i_lzc     (r_lzc1),
        .i_m       (r_m1),
        .i_signed  (r_signed1),
        .i_noscale (r_noscale1),
        .o_m       (w_sel_m),
        .o_shift   (w_sel_shift),
        .o_zero    (w_sel_zero)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_v1       <= 1'b0;
            r_m1       <= '0;
            r_signed1  <= 1'b0;
            r_noscale1 <= 1'b0;
            r_tag1     <= '0;
            r_lzc1     <= '0;
            r_v2       <= 1'b0;
            r_m2       <= '0;
            r_shift2   <= '0;
            r_zero2    <= 1'b0;
            r_tag2     <= '0;
        end else begin
            if (w_s1_load) begin
                r_v1 <= i_valid;
                if (i_valid) begin
                    r_m1       <= i_m;
                    r_signed1  <= i_signed;
                    r_noscale1 <= i_noscale;
                    r_tag1     <= i_tag;
                    r_lzc1     <= w_lzc;
                end
            end
            // Payload only moves with a real transaction so a stalled result stays stable.
            if (w_s2_load) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_m2     <= w_sel_m;
                    r_shift2 <= w_sel_shift;
                    r_zero2  <= w_sel_zero;
                    r_tag2   <= r_tag1;
                end
            end
        end
    end

    assign o_valid = r_v2;
    assign o_m     = r_m2;
    assign o_shift = r_shift2;
    assign o_zero  = r_zero2;
    assign o_tag   = r_tag2;

endmodule

// File: tb/tb_lzd_normalizer.sv
// Bench for lzd_normalizer: directed steps plus random traffic on a 32/8 instance and
// random sweeps on 22/8 and 13/4 instances, each checked against a reference scoreboard.
module tb_lzd_normalizer;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    int compared = 0;
    int failed   = 0;

    // Instance A: WIDTH=32, CHUNK=8
    logic        a_valid, a_ready, a_signed, a_noscale, a_ovalid, a_iready, a_ozero;
    logic [31:0] a_m, a_om;
    logic [3:0]  a_tag, a_otag;
    logic [5:0]  a_oshift;
    // Instance B: WIDTH=22, CHUNK=8
    logic        b_valid, b_ready, b_signed, b_noscale, b_ovalid, b_iready, b_ozero;
    logic [21:0] b_m, b_om;
    logic [3:0]  b_tag, b_otag;
    logic [4:0]  b_oshift;
    // Instance C: WIDTH=13, CHUNK=4
    logic        c_valid, c_ready, c_signed, c_noscale, c_ovalid, c_iready, c_ozero;
    logic [12:0] c_m, c_om;
    logic [3:0]  c_tag, c_otag;
    logic [3:0]  c_oshift;

    logic [42:0] a_q[$];
    logic [42:0] b_q[$];
    logic [42:0] c_q[$];

    lzd_normalizer #(.WIDTH(32), .CHUNK(8)) dut_a (
        .i_clk(clk), .i_nrst(nrst), .i_valid(a_valid), .o_ready(a_ready), .i_m(a_m),
        .i_signed(a_signed), .i_noscale(a_noscale), .i_tag(a_tag), .o_valid(a_ovalid),
        .i_ready(a_iready), .o_m(a_om), .o_shift(a_oshift), .o_zero(a_ozero), .o_tag(a_otag)
    );
    lzd_normalizer #(.WIDTH(22), .CHUNK(8)) dut_b (
        .i_clk(clk), .i_nrst(nrst), .i_valid(b_valid), .o_ready(b_ready), .i_m(b_m),
        .i_signed(b_signed), .i_noscale(b_noscale), .i_tag(b_tag), .o_valid(b_ovalid),
        .i_ready(b_iready), .o_m(b_om), .o_shift(b_oshift), .o_zero(b_ozero), .o_tag(b_otag)
    );
    lzd_normalizer #(.WIDTH(13), .CHUNK(4)) dut_c (
        .i_clk(clk), .i_nrst(nrst), .i_valid(c_valid), .o_ready(c_ready), .i_m(c_m),
        .i_signed(c_signed), .i_noscale(c_noscale), .i_tag(c_tag), .o_valid(c_ovalid),
        .i_ready(c_iready), .o_m(c_om), .o_shift(c_oshift), .o_zero(c_ozero), .o_tag(c_otag)
    );

    // Reference: shift by doubling until the value fills the width (unsigned), or while the
    // scaled signed value still fits in the width (signed).
    function automatic logic [42:0] ref_norm(input logic [31:0] m, input logic sgn,
                                             input logic ns, input logic [3:0] tag, input int w);
        longint unsigned mask, u, om;
        longint          v, lo, hi;
        int              s;
        logic            z;
        mask = (64'd1 << w) - 64'd1;
        u    = {32'd0, m} & mask;
        z    = (u == 64'd0);
        s    = 0;
        om   = u;
        if (!ns && !z) begin
            if (!sgn) begin
                while (om < (64'd1 << (w - 1))) begin
                    om = om * 2;
                    s++;
                end
            end else begin
                lo = -(64'sd1 <<< (w - 1));
                hi = (64'sd1 <<< (w - 1)) - 64'sd1;
                v  = (u >= (64'd1 << (w - 1))) ? $signed(u) - (64'sd1 <<< w) : $signed(u);
                while (s < w - 1 && v * (64'sd1 <<< (s + 1)) >= lo && v * (64'sd1 <<< (s + 1)) <= hi)
                    s++;
                om = (u << s) & mask;
            end
        end
        return {om[31:0], 6'(s), z, tag};
    endfunction

    function automatic logic [31:0] rand_op(input logic sgn);
        logic [31:0] x;
        int          k;
        int          r;
        r = $urandom_range(0, 9);
        x = $urandom;
        k = $urandom_range(0, 31);
        if (r == 0) return 32'd0;
        if (r == 1) return 32'hFFFF_FFFF;
        return sgn ? 32'($signed(x) >>> k) : (x >> k);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: sampled on the falling edge, so fires seen here are those of the next rising edge.
    always @(negedge clk) begin
        if (!nrst) begin
            a_q.delete();
        end else begin
            if (a_ovalid && a_iready) begin
                check("a_nonempty", 64'(a_q.size() != 0), 64'd1);
                if (a_q.size() != 0)
                    check("a_result", {20'd0, a_om, a_oshift, a_ozero, a_otag}, {21'd0, a_q.pop_front()});
            end
            if (a_valid && a_ready) a_q.push_back(ref_norm(a_m, a_signed, a_noscale, a_tag, 32));
        end
    end

    always @(negedge clk) begin
        if (!nrst) begin
            b_q.delete();
        end else begin
            if (b_ovalid && b_iready) begin
                check("b_nonempty", 64'(b_q.size() != 0), 64'd1);
                if (b_q.size() != 0)
                    check("b_result", {21'd0, 32'(b_om), 6'(b_oshift), b_ozero, b_otag}, {21'd0, b_q.pop_front()});
            end
            if (b_valid && b_ready) b_q.push_back(ref_norm(32'(b_m), b_signed, b_noscale, b_tag, 22));
        end
    end

    always @(negedge clk) begin
        if (!nrst) begin
            c_q.delete();
        end else begin
            if (c_ovalid && c_iready) begin
                check("c_nonempty", 64'(c_q.size() != 0), 64'd1);
                if (c_q.size() != 0)
                    check("c_result", {21'd0, 32'(c_om), 6'(c_oshift), c_ozero, c_otag}, {21'd0, c_q.pop_front()});
            end
            if (c_valid && c_ready) c_q.push_back(ref_norm(32'(c_m), c_signed, c_noscale, c_tag, 13));
        end
    end

    task automatic set_a(input logic [31:0] m, input logic sgn, input logic ns, input logic [3:0] tag);
        a_valid   = 1'b1;
        a_m       = m;
        a_signed  = sgn;
        a_noscale = ns;
        a_tag     = tag;
    endtask

    // One transaction on A with i_ready high; the result must be on the output two edges later.
    task automatic send_chk(input string name, input logic [31:0] m, input logic sgn, input logic ns,
                            input logic [3:0] tag, input logic [31:0] em, input logic [5:0] es,
                            input logic ez);
        set_a(m, sgn, ns, tag);
        step();
        a_valid = 1'b0;
        step();
        check({name, "_valid"}, 64'(a_ovalid), 64'd1);
        check(name, {20'd0, a_om, a_oshift, a_ozero, a_otag}, {20'd0, em, es, ez, tag});
    endtask

    task automatic drain_all();
        for (int n = 0; n < 40 && (a_q.size() + b_q.size() + c_q.size()) != 0; n++) step();
        check("drain_a", 64'(a_q.size()), 64'd0);
        check("drain_b", 64'(b_q.size()), 64'd0);
        check("drain_c", 64'(c_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] d [4];
        nrst = 1'b0;
        a_valid = 0; a_m = 0; a_signed = 0; a_noscale = 0; a_tag = 0; a_iready = 1;
        b_valid = 0; b_m = 0; b_signed = 0; b_noscale = 0; b_tag = 0; b_iready = 1;
        c_valid = 0; c_m = 0; c_signed = 0; c_noscale = 0; c_tag = 0; c_iready = 1;
        repeat (2) step();
        check("reset_outputs", {19'd0, a_ovalid, a_om, a_oshift, a_ozero, a_otag}, 64'd0);
        #2 nrst = 1'b1;
        step();
        check("reset_ready", 64'(a_ready), 64'd1);

        send_chk("u_one",      32'h0000_0001, 0, 0, 4'd3, 32'h8000_0000, 6'd31, 1'b0);
        send_chk("u_123456",   32'h0012_3456, 0, 0, 4'd5, 32'h91A2_B000, 6'd11, 1'b0);
        send_chk("u_msb",      32'h8000_0000, 0, 0, 4'd6, 32'h8000_0000, 6'd0,  1'b0);
        send_chk("s_ffffff80", 32'hFFFF_FF80, 1, 0, 4'd7, 32'h8000_0000, 6'd24, 1'b0);
        send_chk("s_minus1",   32'hFFFF_FFFF, 1, 0, 4'd8, 32'h8000_0000, 6'd31, 1'b0);
        send_chk("s_zero",     32'h0000_0000, 1, 0, 4'd9, 32'h0000_0000, 6'd0,  1'b1);
        send_chk("s_plus1",    32'h0000_0001, 1, 0, 4'd10, 32'h4000_0000, 6'd30, 1'b0);
        send_chk("u_zero",     32'h0000_0000, 0, 0, 4'd11, 32'h0000_0000, 6'd0,  1'b1);
        send_chk("noscale",    32'h0000_00F0, 0, 1, 4'd12, 32'h0000_00F0, 6'd0,  1'b0);
        step();

        // Back-to-back mixed noscale/normal at full rate
        for (int i = 0; i < 8; i++) begin
            set_a(rand_op(i[1]), i[1], i[0], 4'(i));
            #1 check("b2b_ready", 64'(a_ready), 64'd1);
            step();
        end
        a_valid = 1'b0;
        drain_all();

        // Backpressure: downstream stalled for three edges
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        a_iready = 1'b0;
        set_a(d[0], 0, 0, 4'd1);
        #1 check("bp_ready0", 64'(a_ready), 64'd1);
        step();
        set_a(d[1], 0, 0, 4'd2);
        #1 check("bp_ready1", 64'(a_ready), 64'd1);
        step();
        set_a(d[2], 0, 0, 4'd3);
        #1 check("bp_ready2", 64'(a_ready), 64'd0);
        check("bp_hold0", {20'd0, a_om, a_oshift, a_ozero, a_otag}, {21'd0, ref_norm(d[0], 0, 0, 4'd1, 32)});
        step();
        check("bp_valid", 64'(a_ovalid), 64'd1);
        check("bp_hold1", {20'd0, a_om, a_oshift, a_ozero, a_otag}, {21'd0, ref_norm(d[0], 0, 0, 4'd1, 32)});
        a_iready = 1'b1;
        step();
        set_a(d[3], 0, 0, 4'd4);
        step();
        a_valid = 1'b0;
        drain_all();

        // Asynchronous reset with both stages full
        a_iready = 1'b0;
        set_a(32'h0000_0010, 0, 0, 4'd5);
        step();
        set_a(32'h0000_0020, 0, 0, 4'd6);
        step();
        a_valid = 1'b0;
        #2 nrst = 1'b0;
        #1 check("midreset_outputs", {19'd0, a_ovalid, a_om, a_oshift, a_ozero, a_otag}, 64'd0);
        step();
        step();
        nrst = 1'b1;
        a_iready = 1'b1;
        #1 check("postreset_ready", 64'(a_ready), 64'd1);
        send_chk("postreset_lat", 32'h0000_0100, 0, 0, 4'd13, 32'h8000_0000, 6'd23, 1'b0);
        step();

        // Random valid/ready bursts on A
        for (int i = 0; i < 400; i++) begin
            logic sg;
            sg = 1'($urandom_range(0, 1));
            set_a(rand_op(sg), sg, ($urandom_range(0, 5) == 0), 4'($urandom));
            a_valid  = ($urandom_range(0, 3) != 0);
            a_iready = ($urandom_range(0, 3) != 0);
            step();
        end
        a_valid  = 1'b0;
        a_iready = 1'b1;
        drain_all();

        // Parameter sweep on the 22/8 and 13/4 instances
        for (int i = 0; i < 600; i++) begin
            b_signed  = 1'($urandom_range(0, 1));
            b_m       = 22'(rand_op(b_signed));
            b_noscale = ($urandom_range(0, 7) == 0);
            b_tag     = 4'($urandom);
            b_valid   = ($urandom_range(0, 3) != 0);
            b_iready  = ($urandom_range(0, 3) != 0);
            c_signed  = 1'($urandom_range(0, 1));
            c_m       = 13'(rand_op(c_signed));
            c_noscale = ($urandom_range(0, 7) == 0);
            c_tag     = 4'($urandom);
            c_valid   = ($urandom_range(0, 3) != 0);
            c_iready  = ($urandom_range(0, 3) != 0);
            step();
        end
        b_valid = 1'b0; b_iready = 1'b1;
        c_valid = 1'b0; c_iready = 1'b1;
        drain_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
